// File: rtl/vga_mon_pkg.sv
// Shared types and defaults for the VGA timing monitor: FSM states, 640x480@60
// timing in 100 MHz clk units, and the CRC-16-CCITT step used for frame signatures.
package vga_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } monState_e;

  localparam int DEF_H_PERIOD_CLKS   = 3200;
  localparam int DEF_H_PULSE_CLKS    = 384;
  localparam int DEF_V_PERIOD_LINES  = 525;
  localparam int DEF_V_PULSE_LINES   = 2;
  localparam int DEF_SYNC_ACTIVE_LOW = 1;
  localparam int DEF_LOCK_FRAMES     = 2;
  localparam int DEF_PIX_DIV         = 4;
  localparam int DEF_H_ACT_START     = 576;
  localparam int DEF_H_ACT_CLKS      = 2560;
  localparam int DEF_V_ACT_START     = 35;
  localparam int DEF_V_ACT_LINES     = 480;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One pixel's worth of CRC: 12 data bits, MSB first.
  function automatic logic [15:0] crc16Step12(input logic [15:0] crcIn,
                                              input logic [11:0] data);
    logic [15:0] c;
    logic        fb;
    c = crcIn;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_crc16.sv
// Running CRC-16-CCITT over 12-bit pixels; clear_i restarts at the init value
// and takes priority over a pixel arriving in the same cycle.
module vga_crc16
  import vga_mon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [11:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16Step12(crc_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Checks VGA hsync/vsync period and width, locks after LOCK_FRAMES clean frames and counts errors.
// Define VGA_MON_CRC_EN to add a per-frame CRC of active pixels (frame_crc/crc_valid).
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_PERIOD_CLKS   = DEF_H_PERIOD_CLKS,
  parameter int H_PULSE_CLKS    = DEF_H_PULSE_CLKS,
  parameter int V_PERIOD_LINES  = DEF_V_PERIOD_LINES,
  parameter int V_PULSE_LINES   = DEF_V_PULSE_LINES,
  parameter int SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int LOCK_FRAMES     = DEF_LOCK_FRAMES,
  parameter int PIX_DIV         = DEF_PIX_DIV,
  parameter int H_ACT_START     = DEF_H_ACT_START,
  parameter int H_ACT_CLKS      = DEF_H_ACT_CLKS,
  parameter int V_ACT_START     = DEF_V_ACT_START,
  parameter int V_ACT_LINES     = DEF_V_ACT_LINES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] err_count,
  output logic [15:0] frame_count,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  logic        hsNorm_q, hsPrev_q, vsNorm_q, vsPrev_q;
  logic        hsRise, hsFall, vsRise, vsFall;
  logic [15:0] hCnt_q, hCnt_d, lineCnt_q, lineCnt_d;
  logic [16:0] hSpan, lineSpan;
  logic        timeout, checking, hErrNow, vErrNow, anyErr;
  monState_e   state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [4:0]  goodInc;
  logic        frameDirty_q, frameDirty_d;
  logic        hErr_q, vErr_q, locked_q;
  logic [15:0] errCount_q, frameCount_q;

  // Syncs are normalised to active-high here, so everything downstream is polarity-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsNorm_q <= 1'b0;
      hsPrev_q <= 1'b0;
      vsNorm_q <= 1'b0;
      vsPrev_q <= 1'b0;
    end else begin
      hsNorm_q <= VGA_HS ^ SYNC_INV;
      hsPrev_q <= hsNorm_q;
      vsNorm_q <= VGA_VS ^ SYNC_INV;
      vsPrev_q <= vsNorm_q;
    end
  end

  assign hsRise = hsNorm_q & ~hsPrev_q;
  assign hsFall = ~hsNorm_q & hsPrev_q;
  assign vsRise = vsNorm_q & ~vsPrev_q;
  assign vsFall = ~vsNorm_q & vsPrev_q;

  // An hsync edge coincident with a vsync edge is counted as the closing frame's last line.
  always_comb begin
    hSpan    = {1'b0, hCnt_q} + 17'd1;
    lineSpan = {1'b0, lineCnt_q} + {16'd0, hsRise};
    hCnt_d   = hsRise ? 16'd0 : ((hCnt_q == 16'hFFFF) ? 16'hFFFF : hCnt_q + 16'd1);
    if (vsRise) begin
      lineCnt_d = 16'd0;
    end else if (hsRise && lineCnt_q != 16'hFFFF) begin
      lineCnt_d = lineCnt_q + 16'd1;
    end else begin
      lineCnt_d = lineCnt_q;
    end
    timeout  = (hCnt_d == 16'hFFFF) && (hCnt_q != 16'hFFFF);
    checking = (state_q != SEARCH);
    hErrNow  = timeout ||
               (checking && ((hsRise && hSpan != 17'(H_PERIOD_CLKS)) ||
                             (hsFall && hSpan != 17'(H_PULSE_CLKS))));
    vErrNow  = checking && ((vsRise && lineSpan != 17'(V_PERIOD_LINES)) ||
                            (vsFall && lineSpan != 17'(V_PULSE_LINES)));
    anyErr   = hErrNow | vErrNow;
  end

  // A frame only counts towards lock if no error was seen anywhere inside it.
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    goodInc      = {1'b0, good_q} + 5'd1;
    frameDirty_d = vsRise ? 1'b0 : (frameDirty_q | anyErr);
    unique case (state_q)
      SEARCH: begin
        if (vsRise) begin
          state_d = LOCKING;
          good_d  = 4'd0;
        end
      end
      LOCKING: begin
        if (anyErr || (vsRise && frameDirty_q)) begin
          good_d = 4'd0;
        end else if (vsRise) begin
          good_d = goodInc[3:0];
          if (goodInc == 5'(LOCK_FRAMES)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (anyErr) begin
          state_d = LOCKING;
          good_d  = 4'd0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = 4'd0;
      end
    endcase
    if (timeout) begin
      state_d = SEARCH;
      good_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hCnt_q       <= 16'd0;
      lineCnt_q    <= 16'd0;
      state_q      <= SEARCH;
      good_q       <= 4'd0;
      frameDirty_q <= 1'b0;
      hErr_q       <= 1'b0;
      vErr_q       <= 1'b0;
      locked_q     <= 1'b0;
      errCount_q   <= 16'd0;
      frameCount_q <= 16'd0;
    end else begin
      hCnt_q       <= hCnt_d;
      lineCnt_q    <= lineCnt_d;
      state_q      <= state_d;
      good_q       <= good_d;
      frameDirty_q <= frameDirty_d;
      hErr_q       <= hErrNow;
      vErr_q       <= vErrNow;
      locked_q     <= (state_q == LOCKED);
      if (anyErr && errCount_q != 16'hFFFF) begin
        errCount_q <= errCount_q + 16'd1;
      end
      if (vsRise && checking) begin
        frameCount_q <= frameCount_q + 16'd1;
      end
    end
  end

  assign locked      = locked_q;
  assign h_err       = hErr_q;
  assign v_err       = vErr_q;
  assign err_count   = errCount_q;
  assign frame_count = frameCount_q;

`ifdef VGA_MON_CRC_EN
  localparam logic [15:0] H_ACT_LO  = 16'(H_ACT_START);
  localparam logic [16:0] H_ACT_HI  = 17'(H_ACT_START + H_ACT_CLKS);
  localparam logic [15:0] V_ACT_LO  = 16'(V_ACT_START);
  localparam logic [16:0] V_ACT_HI  = 17'(V_ACT_START + V_ACT_LINES);
  localparam logic [15:0] PIX_DIV_W = 16'(PIX_DIV);

  logic [11:0] rgb_q;
  logic [15:0] hOff, crcNow, frameCrc_q;
  logic        pixActive, crcValid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 12'd0;
    end else begin
      rgb_q <= {VGA_R, VGA_G, VGA_B};
    end
  end

  // One sample per pixel: the first clk of each PIX_DIV group inside the active window.
  always_comb begin
    hOff      = hCnt_q - H_ACT_LO;
    pixActive = checking &&
                (lineCnt_q >= V_ACT_LO) && ({1'b0, lineCnt_q} < V_ACT_HI) &&
                (hCnt_q >= H_ACT_LO) && ({1'b0, hCnt_q} < H_ACT_HI) &&
                ((hOff % PIX_DIV_W) == 16'd0);
  end

  vga_crc16 u_crc (
    .clk     (clk),
    .reset   (reset),
    .clear_i (vsRise | ~checking),
    .en_i    (pixActive),
    .data_i  (rgb_q),
    .crc_o   (crcNow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      frameCrc_q <= 16'd0;
      crcValid_q <= 1'b0;
    end else begin
      crcValid_q <= vsRise & checking;
      if (vsRise && checking) begin
        frameCrc_q <= crcNow;
      end
    end
  end

  assign frame_crc = frameCrc_q;
  assign crc_valid = crcValid_q;
`else
  logic unusedCrcInputs;
  assign unusedCrcInputs = (^{VGA_R, VGA_G, VGA_B}) ^
                           (^(PIX_DIV + H_ACT_START + H_ACT_CLKS + V_ACT_START + V_ACT_LINES));
  assign frame_crc = 16'd0;
  assign crc_valid = 1'b0;
`endif

endmodule
